// File: rtl/paralelo_serial_tx_pkg.sv
// Purpose: shared constants and state encoding for the parallel-to-serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Also imported by the serial-to-parallel receiver benches so both ends agree
// on the comma byte, sync length and byte width.
package paralelo_serial_tx_pkg;

    localparam int                BYTE_W          = 8;
    localparam logic [BYTE_W-1:0] COMMA_BYTE      = 8'hBC;
    localparam int                SYNC_COMMAS_DEF = 4;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/serializador_8b.sv
// Purpose: 8-bit MSB-first shift register with free-running bit counter.
// Latency: byte on load_dat at a boundary edge appears on data_out over the next 8 edges.
// Backpressure: none; load_dat is always taken at a boundary, caller picks the byte.
// Ports:
//   clk_32f  - bit clock
//   reset    - synchronous active-high reset
//   load_dat - byte loaded into the shift register on a boundary edge
//   data_out - registered serial output (sr[7] of the previous cycle)
//   boundary - high in the cycle whose edge loads the next byte (bit_cnt==7)
module serializador_8b
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_BYTE
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] load_dat,
    output logic              data_out,
    output logic              boundary
);

    localparam int CNT_W = $clog2(BYTE_W);

    logic [BYTE_W-1:0] sr;
    logic [CNT_W-1:0]  bit_cnt;

    assign boundary = (bit_cnt == CNT_W'(BYTE_W - 1));

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            // A comma is preloaded so the first edge after release sends its MSB.
            sr       <= COMMA;
            bit_cnt  <= '0;
            data_out <= 1'b0;
        end else begin
            data_out <= sr[BYTE_W-1];
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (boundary) begin
                sr <= load_dat;
            end else begin
                sr <= {sr[BYTE_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Purpose: parallel-to-serial transmitter; sends SYNC_COMMAS commas, then user bytes or comma idle fill.
// Latency: 1 edge from byte acceptance to its MSB on data_out, 8 edges per byte.
// Backpressure: ready_out pulses one cycle per byte slot; data_in/valid_in ignored otherwise, no buffering.
// Ports:
//   clk_32f   - bit clock, all logic on rising edge
//   reset     - synchronous active-high reset, overrides everything
//   data_in   - byte to send, sampled when ready_out=1
//   valid_in  - data_in holds a real byte, sampled when ready_out=1
//   data_out  - registered serial line, MSB first
//   ready_out - byte-slot boundary, upstream byte consumed on this edge
//   active    - registered, high once the sync commas are out
//   err_comma - registered one-cycle pulse: a valid byte equal to COMMA was accepted
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_BYTE,
    parameter int                SYNC_COMMAS = SYNC_COMMAS_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              data_out,
    output logic              ready_out,
    output logic              active,
    output logic              err_comma
);

    localparam int               CC_W      = $clog2(SYNC_COMMAS + 1);
    localparam logic [CC_W-1:0]  LAST_SYNC = CC_W'(SYNC_COMMAS - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [CC_W-1:0]   comma_cnt;
    logic              boundary;
    logic [BYTE_W-1:0] load_dat;
    logic              err_nxt;

    serializador_8b #(
        .COMMA (COMMA)
    ) u_ser (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .load_dat (load_dat),
        .data_out (data_out),
        .boundary (boundary)
    );

    // State register plus the registered status outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= ST_SYNC;
            comma_cnt <= '0;
            active    <= 1'b0;
            err_comma <= 1'b0;
        end else begin
            state     <= state_nxt;
            active    <= (state_nxt == ST_ACTIVE);
            err_comma <= err_nxt;
            if (state == ST_SYNC && boundary) begin
                comma_cnt <= comma_cnt + CC_W'(1);
            end
        end
    end

    // Next state: SYNC is left only after the last sync comma boundary; ACTIVE is sticky.
    always_comb begin
        state_nxt = state;
        if (state == ST_SYNC && boundary && comma_cnt == LAST_SYNC) begin
            state_nxt = ST_ACTIVE;
        end
    end

    // Outputs: byte selection and handshake. A valid byte equal to COMMA is
    // still sent as a comma (indistinguishable on the line) but flagged.
    always_comb begin
        ready_out = (state == ST_ACTIVE) && boundary;
        load_dat  = COMMA;
        err_nxt   = 1'b0;
        if (ready_out && valid_in) begin
            load_dat = data_in;
            err_nxt  = (data_in == COMMA);
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
module tb_paralelo_serial_tx;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       ready_out;
    logic       active;
    logic       err_comma;

    int         checks   = 0;
    int         failures = 0;
    int         n        = 0;      // edges since reset release
    bit         mon_en   = 1'b0;
    logic [7:0] rx       = 8'h00;
    logic [7:0] exp_q[$];

    paralelo_serial_tx dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .ready_out (ready_out),
        .active    (active),
        .err_comma (err_comma)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, n);
        end
    endtask

    // One clock edge. Before the edge: check ready_out and push the byte the
    // bench expects to be loaded. After the edge: check status outputs and
    // compare every completed serial byte against the scoreboard.
    task automatic tick();
        logic       coll;
        logic       exp_rdy;
        logic [7:0] exp_b;
        coll    = 1'b0;
        exp_rdy = 1'b0;
        if (mon_en) begin
            exp_rdy = (n >= 39) && (n % 8 == 7);
            check("ready_out", 8'(ready_out), 8'(exp_rdy));
            if (exp_rdy) begin
                if (valid_in) begin
                    exp_q.push_back(data_in);
                    coll = (data_in == 8'hBC);
                end else begin
                    exp_q.push_back(8'hBC);
                end
            end
        end
        @(posedge clk_32f);
        #1;
        if (mon_en) begin
            n++;
            check("active", 8'(active), 8'(n >= 32));
            check("err_comma", 8'(err_comma), 8'(coll));
            rx = {rx[6:0], data_out};
            if (n % 8 == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL byte_underflow observed=%h expected=<none> at edge %0d", rx, n);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("serial_byte", rx, exp_b);
                end
            end
        end
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        reset    = 1'b1;
        valid_in = 1'b0;
        tick();
        check("rst_data_out", 8'(data_out), 8'h00);
        check("rst_active", 8'(active), 8'h00);
        check("rst_err_comma", 8'(err_comma), 8'h00);
        check("rst_ready_out", 8'(ready_out), 8'h00);
        tick();
        exp_q.delete();
        n     = 0;
        rx    = 8'h00;
        reset = 1'b0;
        // Preloaded comma plus SYNC_COMMAS commas, all before the first slot.
        repeat (5) exp_q.push_back(8'hBC);
        mon_en = 1'b1;
    endtask

    // One byte slot, starting at a boundary cycle. The other 7 cycles carry
    // valid garbage that must be ignored.
    task automatic send_slot(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        tick();
        repeat (7) begin
            valid_in = 1'b1;
            data_in  = 8'($urandom_range(0, 255));
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Sync: idle input, five commas, first ready before edge 40.
        do_reset();
        tick();
        check("first_bit_after_release", 8'(data_out), 8'h01);
        repeat (38) tick();

        // Held A5: sent every slot with no gaps.
        valid_in = 1'b1;
        data_in  = 8'hA5;
        repeat (24) tick();

        // Idle fill between 3C and F0.
        send_slot(1'b1, 8'h3C);
        send_slot(1'b0, 8'h00);
        send_slot(1'b1, 8'hF0);

        // Comma collision.
        send_slot(1'b1, 8'hBC);
        send_slot(1'b1, 8'hC3);

        // Back-to-back 01..10.
        for (int b = 1; b <= 16; b++) begin
            send_slot(1'b1, 8'(b));
        end

        // Reset three edges into a 55 byte, then a full resync with valid garbage.
        valid_in = 1'b1;
        data_in  = 8'h55;
        tick();
        repeat (3) tick();
        do_reset();
        repeat (39) begin
            valid_in = 1'b1;
            data_in  = 8'($urandom_range(0, 255));
            tick();
        end
        send_slot(1'b1, 8'h7E);
        send_slot(1'b0, 8'h00);
        check("queue_left", 8'(exp_q.size()), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, meaning the idle/sync byte.
REQ-002 SHALL have parameter SYNC_COMMAS, default 4, meaning the number of comma bytes sent before leaving SYNC.
REQ-003 SHALL have clk_32f  input  1  bit clock, single clock domain, all logic on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have data_in  input  8  parallel byte to send; sampled only when ready_out=1.
REQ-006 SHALL have valid_in  input  1  data_in holds a real byte; sampled only when ready_out=1.
REQ-007 SHALL have data_out  output  1  registered serial line, MSB first.
REQ-008 SHALL have ready_out  output  1  byte-slot boundary; upstream byte consumed on this edge.
REQ-009 SHALL have active  output  1  registered; high once sync commas are sent.
REQ-010 SHALL have err_comma  output  1  registered one-cycle pulse; valid byte equal to COMMA was accepted.

Function
REQ-011 SHALL hold an 8-bit shift register sr, a 3-bit bit counter bit_cnt, a comma counter, and a state machine with states SYNC and ACTIVE.
REQ-012 On every non-reset edge, the block SHALL perform three updates: data_out <= sr[7]; bit_cnt <= bit_cnt+1, wrapping 7->0; sr shifts left with 0 fill, except at a boundary.
REQ-013 A boundary SHALL be any edge with bit_cnt==7, and at a boundary sr SHALL load the next byte instead of shifting.
REQ-014 In SYNC, each boundary SHALL load COMMA and increment the comma counter.
REQ-015 At the boundary with comma counter == SYNC_COMMAS-1, the block SHALL go to ACTIVE, set active<=1, and load COMMA.
REQ-016 ready_out SHALL be combinational, equal to (state==ACTIVE && bit_cnt==7), and never high in SYNC.
REQ-017 In ACTIVE at a boundary, sr SHALL load data_in if valid_in=1, else COMMA (idle fill).
REQ-018 Each loaded byte SHALL appear on data_out over the 8 edges following the load edge, MSB first, giving latency of 1 edge from sample to MSB.
REQ-019 If valid_in=1 and data_in==COMMA at a boundary, the block SHALL still send COMMA and SHALL assert err_comma for exactly the next cycle.
REQ-020 err_comma SHALL be 0 in all other cycles.
REQ-021 active SHALL stay 1 until reset, with no return to SYNC except via reset.
REQ-022 valid_in and data_in SHALL be ignored whenever ready_out=0, with no buffering.
REQ-023 Back-to-back valid bytes SHALL be sent with no gap (one byte per 8 edges).

Reset
REQ-024 While reset=1, the block SHALL set data_out=0, active=0, err_comma=0, bit_cnt=0, sr=COMMA, comma counter=0, state=SYNC.
REQ-025 Reset asserted mid-byte or in ACTIVE SHALL abort the current byte at the next edge, with no partial completion.
REQ-026 On release, the first edge SHALL drive data_out=1, the MSB of COMMA.
REQ-027 Reset SHALL take priority over all other updates in the same cycle.

Structure
REQ-028 A shared package SHALL hold COMMA, SYNC_COMMAS, the state encoding, and the byte width, also used by Serial-to-parallel receiver benches.
REQ-029 One sub-module serializador_8b SHALL be used, with sr plus bit_cnt, a load port, and a boundary flag.
REQ-030 The state machine, comma counter, and error logic SHALL live in the top module.
REQ-031 Expected size SHALL be 120-250 lines.

Verification
REQ-032 Sync scenario: release reset, valid_in=0 -> data_out after edges 1..40 = five 8'hBC bytes (10111100 each), active=1 after edge 32, first ready_out in cycle before edge 40.
REQ-033 Single byte scenario: hold data_in=8'hA5, valid_in=1 -> data_out edges 41..48 = 1,0,1,0,0,1,0,1, then A5 repeated every 8 edges, ready_out high 1 of every 8 cycles.
REQ-034 Idle fill scenario: in ACTIVE, valid_in=0 for one slot between 8'h3C and 8'hF0 -> serial stream 3C, BC, F0 with no gaps.
REQ-035 Comma collision scenario: valid_in=1, data_in=8'hBC at boundary -> BC sent, err_comma=1 for exactly one cycle after the boundary.
REQ-036 Mid-operation reset scenario: assert reset 3 edges into an 8'h55 byte in ACTIVE -> data_out=0 and active=0 next edge, then full SYNC sequence on release.
REQ-037 Loopback scenario: connect data_out to Serial_Paralelo data_in (clk_4f = clk_32f/8, aligned to boundaries), send 8'h01..8'h10 -> receiver outputs the same bytes with valid_out=1, and valid_out=0 for BC slots.
